mem_port_arbiter: RTL and testbench

Shares the single unified memory port of the pipeline core between instruction fetch (IF) and data memory (DM) requesters. Grants one transaction at a time, registers the winner's address/data/write-enable onto the port, drives the 2:1 path select (0 = IF, 1 = DM), counts the fixed memory latency, and returns the read data / write acknowledge to the owning requester. Sits between the IF/MEM pipeline stages and the memory model.

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_latency_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states and owner encoding.
// Owner encoding doubles as the mem_sel path-select value.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/arb_latency_ctr.sv
// Memory latency counter: start loads 1, enable increments, clear returns to 0.
// done flags the cycle in which the count equals MEM_LATENCY.
module arb_latency_ctr #(
  parameter int MEM_LATENCY = 2,
  parameter int CW = $clog2(MEM_LATENCY + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  input  logic clr,
  output logic done
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= CW'(1);
    end else if (en) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign done = (count_q == CW'(MEM_LATENCY));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between IF and DM; define ARB_ROUND_ROBIN_EN for
// round-robin on simultaneous requests (default: fixed DM-over-IF priority).
// Handshake: a requester holds *_req (and its fields) until it sees *_gnt high in a cycle;
// the fields are captured on that edge, and *_rvalid pulses for one cycle MEM_LATENCY later.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              state_dbg
);

  state_t state_q, state_d;
  logic   owner_q;
  logic   grant;
  logic   win_dm;
  logic   done;
  logic   busy;

  assign busy = (state_q == BUSY);

`ifdef ARB_ROUND_ROBIN_EN
  // Records who was granted last; reset value IF lets DM win the first tie.
  logic rr_last_q;

  always_comb begin
    win_dm = dm_req && (!if_req || (rr_last_q == OWN_IF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= OWN_IF;
    end else if (grant) begin
      rr_last_q <= win_dm ? OWN_DM : OWN_IF;
    end
  end
`else
  always_comb begin
    win_dm = dm_req;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is asserted so every output reads 0.
        if ((if_req || dm_req) && !rst) begin
          grant   = 1'b1;
          if_gnt  = !win_dm;
          dm_gnt  = win_dm;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= OWN_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= grant;
      if (grant) begin
        owner_q   <= win_dm ? OWN_DM : OWN_IF;
        mem_addr  <= win_dm ? dm_addr : if_addr;
        mem_we    <= win_dm && dm_we;
        mem_wdata <= win_dm ? dm_wdata : '0;
      end
    end
  end

  arb_latency_ctr #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_latency_ctr (
    .clk  (clk),
    .rst  (rst),
    .start(grant),
    .en   (busy && !done),
    .clr  (busy && done),
    .done (done)
  );

  assign mem_sel   = owner_q;
  assign if_rvalid = busy && done && (owner_q == OWN_IF);
  assign dm_rvalid = busy && done && (owner_q == OWN_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-2 instance for the main scenarios and a
// latency-1 instance for back-to-back IF reads.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SB_W = DATA_W + 2;

  logic              clk;
  logic              rst;
  logic              if_req, dm_req, dm_we;
  logic [ADDR_W-1:0] if_addr, dm_addr;
  logic [DATA_W-1:0] dm_wdata, mem_rdata;
  logic              if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] if_rdata, dm_rdata, mem_wdata;
  logic              mem_en, mem_we, mem_sel, state_dbg;
  logic [ADDR_W-1:0] mem_addr;

  logic              if1_req;
  logic [ADDR_W-1:0] if1_addr;
  logic              dm1_req, dm1_we;
  logic [ADDR_W-1:0] dm1_addr;
  logic [DATA_W-1:0] dm1_wdata;
  logic              if1_gnt, if1_rvalid, dm1_gnt, dm1_rvalid;
  logic [DATA_W-1:0] if1_rdata, dm1_rdata, mem1_wdata;
  logic              mem1_en, mem1_we, mem1_sel, state1_dbg;
  logic [ADDR_W-1:0] mem1_addr;

  int checks = 0;
  int errors = 0;
  // Scoreboard entry: {is_write, owner, data}
  logic [SB_W-1:0] exp_q[$];
  logic first_dm;

  mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt), .if_rvalid(if1_rvalid),
    .if_rdata(if1_rdata),
    .dm_req(dm1_req), .dm_we(dm1_we), .dm_addr(dm1_addr), .dm_wdata(dm1_wdata),
    .dm_gnt(dm1_gnt), .dm_rvalid(dm1_rvalid), .dm_rdata(dm1_rdata),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_sel(mem1_sel), .mem_addr(mem1_addr),
    .mem_wdata(mem1_wdata), .mem_rdata(mem_rdata), .state_dbg(state1_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_sel"}, mem_sel, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_dm_gnt"}, dm_gnt, 0);
    check({tag, "_dm_rvalid"}, dm_rvalid, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // Scoreboard: every return pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (!rst && (if_rvalid || dm_rvalid)) begin
      if (exp_q.size() == 0) begin
        check("unexp_rvalid", 1, 0);
      end else begin
        logic [SB_W-1:0] e;
        e = exp_q.pop_front();
        check("rv_owner_dm", dm_rvalid, e[DATA_W]);
        check("rv_owner_if", if_rvalid, !e[DATA_W]);
        if (!e[DATA_W+1])
          check("rv_data", e[DATA_W] ? dm_rdata : if_rdata, e[DATA_W-1:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    if1_req = 0; if1_addr = '0; dm1_req = 0; dm1_we = 0; dm1_addr = '0; dm1_wdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
    first_dm = 1'b0;
`else
    first_dm = 1'b1;
`endif

    tick();
    sample();
    check_idle_outputs("reset");
    check("reset_if_gnt", if_gnt, 0);
    check("reset1_mem_en", mem1_en, 0);

    // IF read of 0x10
    tick();
    rst = 1'b0;
    if_req = 1; if_addr = 32'h0000_0010; mem_rdata = 32'hDEAD_BEEF;
    sample();
    check("ifrd_c0_if_gnt", if_gnt, 1);
    check("ifrd_c0_dm_gnt", dm_gnt, 0);
    exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
    tick(); if_req = 0;
    sample();
    check("ifrd_c1_mem_en", mem_en, 1);
    check("ifrd_c1_mem_sel", mem_sel, 0);
    check("ifrd_c1_mem_addr", mem_addr, 32'h10);
    check("ifrd_c1_mem_we", mem_we, 0);
    check("ifrd_c1_if_rvalid", if_rvalid, 0);
    check("ifrd_c1_if_gnt", if_gnt, 0);
    tick();
    sample();
    check("ifrd_c2_if_rvalid", if_rvalid, 1);
    check("ifrd_c2_mem_en", mem_en, 0);
    check("ifrd_c2_if_rdata", if_rdata, 32'hDEAD_BEEF);
    tick();
    sample();
    check("ifrd_c3_state", state_dbg, 0);
    check("ifrd_c3_if_rvalid", if_rvalid, 0);

    // DM write of 0x1234_5678 to 0x100
    tick();
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'h1234_5678;
    sample();
    check("dmwr_c0_dm_gnt", dm_gnt, 1);
    check("dmwr_c0_if_gnt", if_gnt, 0);
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    tick(); dm_req = 0; dm_we = 0; dm_wdata = '0;
    for (int c = 1; c <= 2; c++) begin
      sample();
      check($sformatf("dmwr_c%0d_mem_we", c), mem_we, 1);
      check($sformatf("dmwr_c%0d_mem_sel", c), mem_sel, 1);
      check($sformatf("dmwr_c%0d_mem_wdata", c), mem_wdata, 32'h1234_5678);
      check($sformatf("dmwr_c%0d_mem_addr", c), mem_addr, 32'h100);
      check($sformatf("dmwr_c%0d_mem_en", c), mem_en, (c == 1));
      check($sformatf("dmwr_c%0d_dm_rvalid", c), dm_rvalid, (c == 2));
      tick();
    end

    // Simultaneous requests
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h30;
    mem_rdata = 32'hCAFE_0001;
    sample();
    check("both_c0_dm_gnt", dm_gnt, first_dm);
    check("both_c0_if_gnt", if_gnt, !first_dm);
    exp_q.push_back({1'b0, first_dm, 32'hCAFE_0001});
    tick();
    if (first_dm) dm_req = 0; else if_req = 0;
    sample();
    check("both_c1_mem_sel", mem_sel, first_dm);
    check("both_c1_mem_addr", mem_addr, first_dm ? 32'h30 : 32'h20);
    check("both_c1_gnt_blocked", if_gnt | dm_gnt, 0);
    tick();
    sample();
    check("both_c2_gnt_blocked", if_gnt | dm_gnt, 0);
    tick();
    sample();
    check("both_c3_dm_gnt", dm_gnt, !first_dm);
    check("both_c3_if_gnt", if_gnt, first_dm);
    exp_q.push_back({1'b0, !first_dm, 32'hCAFE_0001});
    tick(); if_req = 0; dm_req = 0;
    sample();
    check("both_c4_mem_sel", mem_sel, !first_dm);
    check("both_c4_mem_addr", mem_addr, first_dm ? 32'h20 : 32'h30);
    tick();
    tick();

    // Request raised while BUSY
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'h0BAD_F00D;
    sample();
    check("late_c0_if_gnt", if_gnt, 1);
    exp_q.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
    tick(); if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h53;
    sample();
    check("late_c1_dm_gnt", dm_gnt, 0);
    tick();
    sample();
    check("late_c2_dm_gnt", dm_gnt, 0);
    tick();
    sample();
    check("late_c3_dm_gnt", dm_gnt, 1);
    exp_q.push_back({1'b0, 1'b1, 32'h0BAD_F00D});
    tick(); dm_req = 0;
    sample();
    check("late_c4_mem_addr", mem_addr, 32'h53);
    check("late_c4_mem_sel", mem_sel, 1);
    tick();
    tick();

    // Reset in cycle 1 of a DM read aborts it
    dm_req = 1; dm_we = 0; dm_addr = 32'h60;
    sample();
    check("rstmid_c0_dm_gnt", dm_gnt, 1);
    tick(); dm_req = 0;
    sample();
    check("rstmid_c1_mem_en", mem_en, 1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("rstmid_async");
    tick(); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check($sformatf("rstmid_post%0d_dm_rvalid", c), dm_rvalid, 0);
      tick();
    end
    dm_req = 1; dm_we = 0; dm_addr = 32'h70; mem_rdata = 32'h7070_7070;
    sample();
    check("rstmid_next_dm_gnt", dm_gnt, 1);
    exp_q.push_back({1'b0, 1'b1, 32'h7070_7070});
    tick(); dm_req = 0;
    sample();
    check("rstmid_next_mem_addr", mem_addr, 32'h70);
    tick();
    tick();

    // Latency-1 instance, IF requesting continuously
    if1_req = 1; if1_addr = 32'h80; mem_rdata = 32'hA5A5_0000;
    for (int c = 0; c < 6; c++) begin
      sample();
      check($sformatf("l1_c%0d_if_gnt", c), if1_gnt, (c % 2 == 0));
      check($sformatf("l1_c%0d_mem_en", c), mem1_en, (c % 2 == 1));
      check($sformatf("l1_c%0d_if_rvalid", c), if1_rvalid, (c % 2 == 1));
      if (c % 2 == 1) check($sformatf("l1_c%0d_if_rdata", c), if1_rdata, 32'hA5A5_0000);
      tick();
    end
    if1_req = 0;
    tick();
    sample();
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
